sfq_ndrot_cmd_driver: RTL and testbench

//  CMOS-side transmitter/receiver for one NDRO-toggle (NDROT) SFQ cell. Turns SET/RESET/READ

---
 rtl/sfq_ndrot_cmd_driver.sv | 271 +++++++++++++++++++++++++++
 tb/tb_sfq_ndrot_cmd_driver.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sfq_ndrot_cmd_driver.sv
// Command driver for one NDRO-toggle SFQ cell: transition-encoded a/b/clk pulse lines, q toggle decode.
// Optional checker (shadow bit + sticky err) is enabled with `define NDROT_DRV_CHECK_EN.
module sfq_ndrot_cmd_driver #(
  parameter int SET_GAP  = 4,
  parameter int RST_GAP  = 4,
  parameter int READ_GAP = 8,
  parameter int RESP_WIN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_data,
  output logic       a_o,
  output logic       b_o,
  output logic       clk_o,
  input  logic       q_i,
  output logic       err
);

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  localparam int MAXP = max2(max2(SET_GAP, RST_GAP), max2(READ_GAP, RESP_WIN));
  localparam int CW   = (MAXP < 1) ? 1 : $clog2(MAXP + 1);

  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_RST  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_WAIT_Q = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_seen;
  logic            w_seen_nxt;
  logic            r_q_meta;
  logic            r_q_s;
  logic            r_q_prev;
  logic            r_a;
  logic            r_b;
  logic            r_clk;
  logic            w_a_nxt;
  logic            w_b_nxt;
  logic            w_clk_nxt;
  logic            r_rsp_valid;
  logic            r_rsp_data;
  logic            w_rsp_valid_nxt;
  logic            w_rsp_data_nxt;
  logic            r_ready;
  logic            w_accept;
  logic            w_qedge;
  logic            w_win_last;
  logic            w_resp_fire;

  assign w_qedge     = r_q_s ^ r_q_prev;
  assign w_accept    = cmd_valid & r_ready & (r_state == S_IDLE);
  assign w_win_last  = (r_state == S_WAIT_Q) && (r_cnt <= CW'(1));
  assign w_resp_fire = w_win_last;

  assign cmd_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign a_o       = r_a;
  assign b_o       = r_b;
  assign clk_o     = r_clk;

  // q_i is asynchronous to clk: two-flop synchronizer plus previous-value flop for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_meta <= 1'b0;
      r_q_s    <= 1'b0;
      r_q_prev <= 1'b0;
    end else begin
      r_q_meta <= q_i;
      r_q_s    <= r_q_meta;
      r_q_prev <= r_q_s;
    end
  end

  // FSM state and spacing/window counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= {CW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; a zero gap skips HOLD entirely
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_SET: begin
              if (SET_GAP != 0) begin
                w_state_nxt = S_HOLD;
                w_cnt_nxt   = CW'(SET_GAP);
              end else begin
                w_state_nxt = S_IDLE;
              end
            end
            OP_RST: begin
              if (RST_GAP != 0) begin
                w_state_nxt = S_HOLD;
                w_cnt_nxt   = CW'(RST_GAP);
              end else begin
                w_state_nxt = S_IDLE;
              end
            end
            OP_READ: begin
              w_state_nxt = S_WAIT_Q;
              w_cnt_nxt   = CW'(RESP_WIN);
            end
            default: begin
              w_state_nxt = S_IDLE;
            end
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        if (r_cnt <= CW'(1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = {CW{1'b0}};
        end else begin
          w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      S_WAIT_Q: begin
        if (r_cnt <= CW'(1)) begin
          w_state_nxt = S_RESP;
          w_cnt_nxt   = {CW{1'b0}};
        end else begin
          w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready && r_rsp_valid) begin
          if (READ_GAP != 0) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = CW'(READ_GAP);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {CW{1'b0}};
      end
    endcase
  end

  // Output next-values: pulse toggles on accept, window accumulation, response handshake
  always_comb begin
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_clk_nxt       = r_clk;
    w_seen_nxt      = r_seen;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_SET:  w_a_nxt = ~r_a;
            OP_RST:  w_b_nxt = ~r_b;
            OP_READ: begin
              w_clk_nxt  = ~r_clk;
              w_seen_nxt = 1'b0;
            end
            default: w_a_nxt = r_a;
          endcase
        end else begin
          w_seen_nxt = r_seen;
        end
      end
      S_WAIT_Q: begin
        w_seen_nxt = r_seen | w_qedge;
        if (w_win_last) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = r_seen | w_qedge;
        end else begin
          w_rsp_valid_nxt = 1'b0;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
        end else begin
          w_rsp_valid_nxt = r_rsp_valid;
        end
      end
      default: begin
        w_rsp_valid_nxt = r_rsp_valid;
      end
    endcase
  end

  // Registered outputs; cmd_ready stays low through reset and rises on the first edge after release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_clk       <= 1'b0;
      r_seen      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_clk       <= w_clk_nxt;
      r_seen      <= w_seen_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_ready     <= (w_state_nxt == S_IDLE);
    end
  end

`ifdef NDROT_DRV_CHECK_EN
  logic r_shadow;
  logic r_err;
  logic w_err_set;

  assign w_err_set = (w_resp_fire && (w_rsp_data_nxt != r_shadow))
                   || (w_qedge && (r_state != S_WAIT_Q))
                   || ((r_state == S_WAIT_Q) && r_seen && w_qedge);
  assign err = r_err;

  // Shadow of the expected cell state and sticky err flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept && (cmd_op == OP_SET)) begin
        r_shadow <= 1'b1;
      end else if (w_accept && (cmd_op == OP_RST)) begin
        r_shadow <= 1'b0;
      end else begin
        r_shadow <= r_shadow;
      end
      r_err <= r_err | w_err_set;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sfq_ndrot_cmd_driver.sv
// Directed bench for sfq_ndrot_cmd_driver with a read-response scoreboard queue.
module tb_sfq_ndrot_cmd_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       rsp_ready;
  logic       q_i;
  logic       cmd_ready, rsp_valid, rsp_data, a_o, b_o, clk_o, err;

  logic       c0_valid;
  logic [1:0] c0_op;
  logic       c0_rsp_ready;
  logic       c0_q;
  logic       c0_ready, c0_rsp_valid, c0_rsp_data, c0_a, c0_b, c0_clk, c0_err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sfq_ndrot_cmd_driver u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .a_o(a_o), .b_o(b_o), .clk_o(clk_o), .q_i(q_i), .err(err)
  );

  sfq_ndrot_cmd_driver #(.SET_GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(c0_valid), .cmd_ready(c0_ready), .cmd_op(c0_op),
    .rsp_valid(c0_rsp_valid), .rsp_ready(c0_rsp_ready), .rsp_data(c0_rsp_data),
    .a_o(c0_a), .b_o(c0_b), .clk_o(c0_clk), .q_i(c0_q), .err(c0_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Offer a command, wait (bounded) for ready, return the accept edge number
  task automatic send(input logic [1:0] op, output int t);
    int n;
    n = 0;
    cmd_op = op;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("accept_timeout", (n < 50), 1);
    tick();
    t = cyc;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
  endtask

  task automatic wait_rsp(output int t);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("rsp_timeout", (n < 50), 1);
    t = cyc;
  endtask

  task automatic pop_cmp(input string tag);
    logic e;
    chk({tag, "_queue_nonempty"}, (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(tag, rsp_data, e);
    end else begin
      e = 1'b0;
    end
  endtask

  initial begin
    int t, t0, te, t1, t2, n;
    logic prev, d0, anyv;
    logic [2:0] lines;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; rsp_ready = 1'b0; q_i = 1'b0;
    c0_valid = 1'b0; c0_op = 2'b00; c0_rsp_ready = 1'b0; c0_q = 1'b0;
    tick(); tick(); tick();
    chk("reset_outputs", {a_o, b_o, clk_o, rsp_valid, rsp_data, err}, 0);
    chk("reset_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_release", cmd_ready, 1);

`ifdef NDROT_DRV_CHECK_EN
    chk("chk_err_init", err, 0);
    send(2'b01, t);
    send(2'b11, t0);
    exp_q.push_back(1'b0);
    wait_rsp(t);
    pop_cmp("chk_rsp_mismatch");
    chk("chk_err_set", err, 1);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    send(2'b10, t);
    tick();
    chk("chk_err_sticky", err, 1);
    rst_pulse();
    chk("chk_err_cleared", err, 0);
    q_i = ~q_i;
    tick(); tick(); tick(); tick();
    chk("chk_err_stray_q", err, 1);
    q_i = ~q_i;
    tick(); tick(); tick(); tick();
    rst_pulse();
`endif

    // SET then READ with a q toggle three cycles after clk_o
    send(2'b01, t);
    chk("set_a_o", a_o, 1);
    chk("set_busy", cmd_ready, 0);
    send(2'b11, t0);
    chk("read_clk_o", clk_o, 1);
    exp_q.push_back(1'b1);
    tick(); tick(); tick();
    q_i = ~q_i;
    wait_rsp(t);
    chk("read1_latency", t - t0, 8);
    pop_cmp("read1_data");
`ifndef NDROT_DRV_CHECK_EN
    chk("err_tied_low", err, 0);
`endif
    rsp_ready = 1'b1;
    tick();
    te = cyc;
    rsp_ready = 1'b0;
    chk("read1_rsp_drop", rsp_valid, 0);
    send(2'b00, t);
    chk("read_gap_accept", t - te, 9);
    send(2'b00, t1);
    chk("nop_back_to_back", t1 - t, 1);

    // RESET then READ with q held; response held off for 5 cycles
    send(2'b10, t);
    chk("reset_b_o", b_o, 1);
    send(2'b11, t0);
    exp_q.push_back(1'b0);
    wait_rsp(t);
    chk("read2_latency", t - t0, 8);
    d0 = rsp_data;
    lines = {a_o, b_o, clk_o};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_data, d0);
      chk("stall_ready", cmd_ready, 0);
      chk("stall_lines", {a_o, b_o, clk_o}, lines);
    end
    pop_cmp("read2_data");
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("read2_rsp_drop", rsp_valid, 0);

    // SET,SET with cmd_valid held: toggle spacing SET_GAP+1
    cmd_op = 2'b01;
    cmd_valid = 1'b1;
    prev = a_o; t1 = -1; t2 = -1; n = 0;
    while (t2 < 0 && n < 40) begin
      tick();
      n++;
      if (a_o !== prev) begin
        if (t1 < 0) t1 = cyc;
        else begin
          t2 = cyc;
          cmd_valid = 1'b0;
        end
      end
      prev = a_o;
    end
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    chk("setset_found", (t2 >= 0), 1);
    chk("setset_spacing", t2 - t1, 5);

    // Same with SET_GAP=0: consecutive toggles
    c0_op = 2'b01;
    c0_valid = 1'b1;
    prev = c0_a; t1 = -1; t2 = -1; n = 0;
    while (t2 < 0 && n < 10) begin
      tick();
      n++;
      if (c0_a !== prev) begin
        if (t1 < 0) t1 = cyc;
        else t2 = cyc;
      end
      prev = c0_a;
    end
    c0_valid = 1'b0;
    chk("gap0_found", (t2 >= 0), 1);
    chk("gap0_spacing", t2 - t1, 1);

    // rst during WAIT_Q: immediate clear, no response
    send(2'b11, t0);
    tick(); tick();
    #1 rst = 1'b1;
    #1 chk("midrst_outputs", {a_o, b_o, clk_o, rsp_valid, rsp_data, cmd_ready}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("midrst_ready", cmd_ready, 1);
    anyv = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      anyv = anyv | rsp_valid;
    end
    chk("midrst_no_rsp", anyv, 0);
    send(2'b10, t);
    chk("reinit_b_o", b_o, 1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
